// File: rtl/bsg_skid_buffer_pkg.sv
// Shared types and constants for the two-entry skid buffer.
// Optional feature macro: BSG_SKID_BUFFER_STALL_CNT_EN (adds stall_cnt_o).
package bsg_skid_buffer_pkg;

   // Occupancy of the buffer: nothing held, main register only, main + skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   // Width of the optional upstream stall counter.
   localparam int stall_cnt_width_gp = 16;

endpackage : bsg_skid_buffer_pkg

// File: rtl/bsg_dff_en.sv
// Enabled payload register: loads data_i on a rising clk_i edge when en_i is
// high, otherwise holds. Payload is deliberately not reset.
module bsg_dff_en #(
   parameter int width_p  = 32,
   parameter int harden_p = 0
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] data_r;

   if (harden_p != 0) begin : g_hard
      // Hardened variant: the generic library maps it onto the same enabled flop.
      // NOTE: no reset on payload storage -- validity is tracked by the control
      // FSM, so clearing data would only add reset fan-out for no benefit.
      always_ff @(posedge clk_i) begin
         if (en_i) data_r <= data_i;
      end
   end else begin : g_soft
      // Generic enabled flop; holds whenever en_i is low.
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      always_ff @(posedge clk_i) begin
         if (en_i) data_r <= data_i;
      end
   end

   assign data_o = data_r;

endmodule : bsg_dff_en

// File: rtl/bsg_skid_buffer.sv
// Two-entry skid buffer (main + skid register) with fully registered
// handshake outputs: ready_o and v_o depend only on state, so there is no
// combinational path from any input to any output.
// Optional feature macro: BSG_SKID_BUFFER_STALL_CNT_EN adds a saturating
// 16-bit count of cycles where upstream offered data while ready_o was low.
module bsg_skid_buffer
   import bsg_skid_buffer_pkg::*;
#(
   parameter int width_p  = 32,
   parameter int harden_p = 0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  ,output logic [stall_cnt_width_gp-1:0] stall_cnt_o
`endif
);

   state_e             state_r;
   logic               v_r;
   logic               ready_r;
   logic               enq;
   logic               deq;
   logic               main_en;
   logic               skid_en;
   logic               main_sel_skid;
   logic [width_p-1:0] main_d;
   logic [width_p-1:0] skid_q;

   assign enq = v_i & ready_r;
   assign deq = v_r & ready_i;

   // Occupancy FSM with registered valid/ready; reset forces both low.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= EMPTY;
         v_r     <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         case (state_r)
            EMPTY: begin
               ready_r <= 1'b1;
               if (enq) begin
                  state_r <= ONE;
                  v_r     <= 1'b1;
               end
            end
            ONE: begin
               case ({enq, deq})
                  2'b10: begin
                     state_r <= FULL;
                     v_r     <= 1'b1;
                     ready_r <= 1'b0;
                  end
                  2'b01: begin
                     state_r <= EMPTY;
                     v_r     <= 1'b0;
                     ready_r <= 1'b1;
                  end
                  default: begin
                     state_r <= ONE;
                     v_r     <= 1'b1;
                     ready_r <= 1'b1;
                  end
               endcase
            end
            FULL: begin
               if (deq) begin
                  state_r <= ONE;
                  v_r     <= 1'b1;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               state_r <= EMPTY;
               v_r     <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   // Register write enables and main-register source, decoded from state.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      main_en       = 1'b0;
      skid_en       = 1'b0;
      main_sel_skid = 1'b0;
      case (state_r)
         EMPTY: main_en = enq;
         ONE: begin
            main_en = enq & deq;
            skid_en = enq & ~deq;
         end
         FULL: begin
            main_en       = deq;
            main_sel_skid = 1'b1;
         end
         default: ;
      endcase
   end

   assign main_d = main_sel_skid ? skid_q : data_i;

   bsg_dff_en #(.width_p(width_p), .harden_p(harden_p)) main_reg (
      .clk_i  (clk_i),
      .en_i   (main_en),
      .data_i (main_d),
      .data_o (data_o)
   );

   bsg_dff_en #(.width_p(width_p), .harden_p(harden_p)) skid_reg (
      .clk_i  (clk_i),
      .en_i   (skid_en),
      .data_i (data_i),
      .data_o (skid_q)
   );

   assign ready_o = ready_r;
   assign v_o     = v_r;

`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
   logic [stall_cnt_width_gp-1:0] stall_cnt_r;

   // Count upstream stall cycles, saturating at all-ones.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cnt_r <= '0;
      end else if (v_i & ~ready_r & ~(&stall_cnt_r)) begin
         stall_cnt_r <= stall_cnt_r + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt_r;
`endif

endmodule : bsg_skid_buffer

// File: tb/tb_bsg_skid_buffer.sv
// Self-checking bench for bsg_skid_buffer: directed scenarios plus a long
// randomized run, checked by a queue-based reference FIFO of depth two.
module tb_bsg_skid_buffer;

   localparam int W = 32;

   logic         clk_i;
   logic         reset_i;
   logic         v_i;
   logic [W-1:0] data_i;
   logic         ready_o;
   logic         v_o;
   logic [W-1:0] data_o;
   logic         ready_i;
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
   logic [15:0]  stall_cnt_o;
`endif

   bsg_skid_buffer #(.width_p(W), .harden_p(0)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .ready_i (ready_i)
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
     ,.stall_cnt_o (stall_cnt_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int           compared   = 0;
   int           mismatched = 0;
   logic [W-1:0] exp_q[$];
   int           stall_model = 0;
   bit           live;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Buffer becomes usable at the first clock edge after reset releases.
   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) live <= 1'b0;
      else         live <= 1'b1;
   end

   // Monitor / scoreboard: a 2-deep FIFO model decides what the DUT must show,
   // which transfers happen at the coming edge, and keeps the expected data.
   always @(negedge clk_i) begin
      bit exp_v;
      bit exp_rdy;
      if (reset_i) begin
         exp_q.delete();
         stall_model = 0;
      end else begin
         exp_v   = live && (exp_q.size() > 0);
         exp_rdy = live && (exp_q.size() < 2);
         check("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
         check("v_o", {31'd0, v_o}, {31'd0, exp_v});
         if (exp_v) check("data_o", data_o, exp_q[0]);
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
         check("stall_cnt_o", {16'd0, stall_cnt_o}, stall_model[W-1:0]);
         if (v_i && !exp_rdy && stall_model < 65535) stall_model++;
`endif
         if (exp_v && ready_i) void'(exp_q.pop_front());
         if (v_i && exp_rdy) exp_q.push_back(data_i);
      end
   end

   // Apply one cycle of stimulus; returns 1 time unit after the sampling edge.
   task automatic step(input logic v, input logic [W-1:0] d, input logic r);
      v_i     = v;
      data_i  = d;
      ready_i = r;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int pv;
      int pr;
      reset_i = 1'b1;
      v_i     = 1'b0;
      data_i  = '0;
      ready_i = 1'b0;
      #3;
      check("reset v_o", {31'd0, v_o}, 32'd0);
      check("reset ready_o", {31'd0, ready_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
      step(1'b0, '0, 1'b1);
      check("post-reset ready_o", {31'd0, ready_o}, 32'd1);
      check("post-reset v_o", {31'd0, v_o}, 32'd0);

      // Single word, one-cycle latency.
      step(1'b1, 32'hA5A5_0001, 1'b1);
      check("latency v_o", {31'd0, v_o}, 32'd1);
      check("latency data_o", data_o, 32'hA5A5_0001);
      step(1'b0, '0, 1'b1);

      // Back-pressure: 1 and 2 accepted, 3 held off, then drained in order.
      step(1'b1, 32'd1, 1'b0);
      step(1'b1, 32'd2, 1'b0);
      step(1'b1, 32'd3, 1'b0);
      check("full ready_o", {31'd0, ready_o}, 32'd0);
      check("full data_o", data_o, 32'd1);
      step(1'b1, 32'd3, 1'b0);
      check("full hold data_o", data_o, 32'd1);
      step(1'b1, 32'd3, 1'b1);
      check("drain ready_o", {31'd0, ready_o}, 32'd1);
      check("drain data_o 2", data_o, 32'd2);
      step(1'b1, 32'd3, 1'b1);
      check("drain data_o 3", data_o, 32'd3);
      step(1'b0, '0, 1'b1);
      check("drained v_o", {31'd0, v_o}, 32'd0);

      // Simultaneous enqueue and dequeue while holding one word.
      step(1'b1, 32'd6, 1'b0);
      step(1'b1, 32'd7, 1'b1);
      check("pass data_o", data_o, 32'd7);
      check("pass ready_o", {31'd0, ready_o}, 32'd1);
      check("pass v_o", {31'd0, v_o}, 32'd1);
      step(1'b0, '0, 1'b1);

      // Downstream ready with nothing valid must not disturb the empty buffer.
      repeat (3) step(1'b0, '0, 1'b1);
      check("idle v_o", {31'd0, v_o}, 32'd0);
      check("idle ready_o", {31'd0, ready_o}, 32'd1);

      // Asynchronous reset while full: outputs drop at once, nothing stale later.
      step(1'b1, 32'd8, 1'b0);
      step(1'b1, 32'd9, 1'b0);
      check("pre-reset ready_o", {31'd0, ready_o}, 32'd0);
      #2 reset_i = 1'b1;
      #1;
      check("async reset v_o", {31'd0, v_o}, 32'd0);
      check("async reset ready_o", {31'd0, ready_o}, 32'd0);
      v_i = 1'b0;
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      step(1'b0, '0, 1'b1);
      check("re-reset ready_o", {31'd0, ready_o}, 32'd1);
      repeat (3) step(1'b0, '0, 1'b1);
      check("no stale v_o", {31'd0, v_o}, 32'd0);

      // Randomized traffic with varying valid/ready densities.
      for (int seg = 0; seg < 10; seg++) begin
         pv = (seg % 3 == 0) ? 25 : (seg % 3 == 1) ? 60 : 90;
         pr = (seg % 4 == 0) ? 20 : (seg % 4 == 1) ? 50 : (seg % 4 == 2) ? 80 : 95;
         for (int c = 0; c < 1000; c++) begin
            step(($urandom_range(0, 99) < pv), $urandom, ($urandom_range(0, 99) < pr));
         end
      end

      repeat (4) step(1'b0, '0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_bsg_skid_buffer

// File: doc/bsg_skid_buffer.md
BSG_SKID_BUFFER -- requirements
Module: bsg_skid_buffer

Interface
REQ-001 SHALL have parameter: width_p, 32, payload width in bits (legal range 1..1024).
REQ-002 SHALL have parameter: harden_p, 0, forwarded unchanged to the data-register sub-module instances.
REQ-003 SHALL have port: clk_i  input  1  sole clock; all state samples on its rising edge.
REQ-004 SHALL have port: reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: v_i  input  1  upstream valid.
REQ-006 SHALL have port: data_i  input  width_p  upstream payload.
REQ-007 SHALL have port: ready_o  output  1  upstream ready; registered, and a function of state only.
REQ-008 SHALL have port: v_o  output  1  downstream valid.
REQ-009 SHALL have port: data_o  output  width_p  downstream payload, driven from the main register.
REQ-010 SHALL have port: ready_i  input  1  downstream ready.

Function
REQ-011 SHALL implement a 2-entry FIFO: main register plus skid register; states EMPTY, ONE, FULL.
REQ-012 SHALL define enq = v_i & ready_o and deq = v_o & ready_i; when ready_o=0, v_i is ignored.
REQ-013 SHALL make ready_o=1 in EMPTY and ONE and 0 in FULL; v_o=1 in ONE and FULL.
REQ-014 SHALL make enqueued data visible on data_o with v_o=1 in the cycle after the enq edge (1-cycle latency); no combinational path from inputs to outputs.
REQ-015 SHALL implement the EMPTY transitions: enq -> ONE, loading the main register.
REQ-016 SHALL implement the ONE transitions: enq & deq -> ONE, main loads data_i; enq only -> FULL, skid loads data_i; deq only -> EMPTY.
REQ-017 SHALL implement the FULL transitions: deq -> ONE, main loads skid; otherwise hold.
REQ-018 SHALL preserve FIFO order with no loss or duplication of data.
REQ-019 SHALL write each register only via its enable; when not enabled, the register holds its value.
REQ-020 SHALL keep data_o stable while v_o=1 and deq=0.

Reset
REQ-021 SHALL, while reset_i=1 (asynchronously), force state EMPTY, v_o=0 and ready_o=0.
REQ-022 SHALL present ready_o=1 and v_o=0 in the first cycle after reset_i deasserts.
REQ-023 SHALL not reset the payload registers; data_o is don't-care while v_o=0.
REQ-024 SHALL discard all held entries on reset asserted mid-operation, with no partial transfer.

Configuration
REQ-025 SHALL, with BSG_SKID_BUFFER_STALL_CNT_EN defined, add output stall_cnt_o (16 bits), reset to 0, incrementing each cycle v_i=1 & ready_o=0, saturating at 16'hFFFF.
REQ-026 SHALL, without BSG_SKID_BUFFER_STALL_CNT_EN, have neither the stall_cnt_o port nor the counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL take the state enum typedef (EMPTY/ONE/FULL, 2 bits) and the stall-counter width constant from package bsg_skid_buffer_pkg.
REQ-028 SHALL build the main and skid registers from two instances of sub-module bsg_dff_en (width_p, harden_p), driving each instance's en_i from the FSM.

Verification
REQ-029 SHALL cover: reset, then v_i=1, data_i=32'hA5A5_0001, ready_i=1 -> one cycle later v_o=1, data_o=32'hA5A5_0001.
REQ-030 SHALL cover: ready_i=0 with 3 words 1,2,3 offered back-to-back -> 1 and 2 accepted, ready_o=0 and 3 held; ready_i=1 -> outputs 1,2,3 in order.
REQ-031 SHALL cover: ONE state with simultaneous enq(7) and deq(6) -> 6 consumed, data_o=7 next cycle, state ONE, ready_o stays 1.
REQ-032 SHALL cover: FULL state, reset_i pulsed mid-cycle -> v_o=0 and ready_o=0 immediately; after release ready_o=1 and no stale data emitted.
REQ-033 SHALL cover: 10,000 cycles of random v_i/ready_i against a scoreboard -> zero mismatches; with BSG_SKID_BUFFER_STALL_CNT_EN, stall_cnt_o equals the model's count.
REQ-034 SHALL cover: v_o=0 with ready_i=1 -> no state change and no spurious deq.
